counter_4bit_load: RTL and testbench

4-bit synchronous up-counter with asynchronous active-low clear and a synchronous parallel load. It is a free-running event/cycle counter for small control blocks: it counts every clock unless it is being loaded. Terminal count wraps from 15 to 0. It has no handshake; `count` is a registered output that downstream logic may sample every cycle.

---
 rtl/counter_4bit_load.sv | 35 +++
 tb/tb_counter_4bit_load.sv | 118 +++++++++++
 2 files changed

// File: rtl/counter_4bit_load.sv
// 4-bit free-running up-counter: async active-low clear, synchronous parallel load, wraps 15 -> 0.
// Define COUNTER_4BIT_LOAD_ASSERT_EN to compile in simulation-only property checks.
module counter_4bit_load (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_data,
  output logic [3:0] count
);

  // Priority is reset, then load, then increment; the add wraps naturally at 4 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= 4'h0;
    else if (load) count <= load_data;
    else           count <= count + 4'd1;
  end

`ifdef COUNTER_4BIT_LOAD_ASSERT_EN
  a_rst_clear: assert property (@(posedge clk) !reset_n |-> count == 4'h0)
    else $error("count not clear during reset");

  a_load: assert property (@(posedge clk) disable iff (!reset_n)
    load |=> count == $past(load_data))
    else $error("load value not captured");

  a_inc: assert property (@(posedge clk) disable iff (!reset_n)
    !load |=> count == 4'($past(count) + 4'd1))
    else $error("count did not increment");

  a_known: assert property (@(posedge clk) reset_n |-> !$isunknown({load, load_data}))
    else $error("load/load_data unknown out of reset");
`else
`endif

endmodule

// File: tb/tb_counter_4bit_load.sv
// Directed bench for counter_4bit_load: arithmetic reference model checked every cycle plus literal expectations.
module tb_counter_4bit_load;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] load_data;
  logic [3:0] count;

  int errs   = 0;
  int checks = 0;
  int m      = 0;
  bit mv     = 1'b0;

  always #5 clk = ~clk;

  counter_4bit_load dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_data(load_data), .count(count)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer value, cleared by reset, replaced by load, otherwise +1 modulo 16.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m  = 0;
      mv = 1'b1;
    end else if (mv) begin
      if (load) m = int'(load_data);
      else      m = (m + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (mv) check("model", count, 4'(m));
  end

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout expected finish");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b1;
    load      = 1'b0;
    load_data = 4'h0;
    #2;
    // Reset held with a load pending: must never capture A.
    reset_n   = 1'b0;
    load      = 1'b1;
    load_data = 4'hA;
    #1 check("rst_assert", count, 4'h0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", count, 4'h0);
    end

    // Release away from an edge; count 1..5.
    reset_n = 1'b1;
    load    = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("count_up", count, 4'(i));
    end

    // Back to 0, then 16 edges: F on edge 15, 0 on edge 16.
    load = 1'b1; load_data = 4'h0;
    @(negedge clk); check("load_zero", count, 4'h0);
    load = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("wrap_run", count, 4'(i % 16));
    end

    // Repeated load of F holds F; dropping load wraps to 0.
    load = 1'b1; load_data = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_F", count, 4'hF);
    end
    load = 1'b0;
    @(negedge clk); check("F_wrap", count, 4'h0);

    // Load beats terminal count.
    load = 1'b1; load_data = 4'hF;
    @(negedge clk); check("load_F", count, 4'hF);
    load_data = 4'h3;
    @(negedge clk); check("load_over_tc", count, 4'h3);
    load = 1'b0;
    @(negedge clk); check("after_load", count, 4'h4);

    // Async reset mid-cycle while at 7.
    load = 1'b1; load_data = 4'h7;
    @(negedge clk); check("load_7", count, 4'h7);
    load = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_rst", count, 4'h0);

    // Release coincident with a rising edge: that edge still sees reset.
    @(posedge clk);
    reset_n <= 1'b1;
    #1 check("rel_edge", count, 4'h0);
    @(posedge clk);
    #1 check("first_inc", count, 4'h1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
